// File: rtl/ram_seq_pkg.sv
// Shared types and constants for the RAM access sequencer.
package ram_seq_pkg;

  localparam int unsigned RAM_SEQ_CNT_W      = 4;
  localparam int unsigned RAM_SEQ_MAX_ACCESS = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } ram_seq_state_t;

  typedef enum logic {
    SRC_FETCH = 1'b0,
    SRC_DATA  = 1'b1
  } ram_seq_src_t;

endpackage

// File: rtl/ram_seq_arb.sv
// Two-way fetch/data arbiter.
// Build option RAM_SEQ_FIXED_PRI_EN: data always wins a tie and no last-grant
// state is kept; otherwise ties alternate, starting with fetch after reset.
// o_grant_src_c encoding: 1 = data, 0 = fetch.
module ram_seq_arb
  import ram_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_fetch_req,
  input  logic i_data_req,
  input  logic i_advance,
  output logic o_grant_valid_c,
  output logic o_grant_src_c
);

  assign o_grant_valid_c = i_fetch_req | i_data_req;

`ifdef RAM_SEQ_FIXED_PRI_EN
  logic w_unused;
  assign w_unused = clk ^ rst_n ^ i_advance;

  // Data has priority; fetch only when data is not requesting
  always_comb begin
    o_grant_src_c = i_data_req;
  end
`else
  logic r_last_data;

  // Remember which source was granted last; resets to data so fetch wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_data <= 1'b1;
    end else if (i_advance && o_grant_valid_c) begin
      r_last_data <= o_grant_src_c;
    end
  end

  // Single request wins outright; a tie goes to the source not granted last
  always_comb begin
    o_grant_src_c = i_data_req;
    if (i_fetch_req && i_data_req) begin
      o_grant_src_c = ~r_last_data;
    end
  end
`endif

endmodule

// File: rtl/ram_access_seq.sv
// RAM access sequencer: arbitrates fetch/data requests and drives the address
// enable plus RAM strobes through a setup / strobe / hold sequence.
// Build option RAM_SEQ_FIXED_PRI_EN selects fixed data-over-fetch priority.
module ram_access_seq
  import ram_seq_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fetch_req,
  output logic fetch_ack,
  input  logic data_req,
  input  logic data_we,
  output logic data_ack,
  output logic ip_w,
  output logic m_w,
  output logic ram_r,
  output logic ram_w,
  output logic busy
);

  localparam logic [RAM_SEQ_CNT_W-1:0] LP_CNT_INIT = RAM_SEQ_CNT_W'(ACCESS_CYCLES - 1);

  // Strobe length must fit the 4-bit down-counter and be at least one cycle
  if ((ACCESS_CYCLES == 0) || (ACCESS_CYCLES > RAM_SEQ_MAX_ACCESS)) begin : g_bad_cycles
    $fatal(1, "ram_access_seq: ACCESS_CYCLES=%0d outside 1..%0d",
           ACCESS_CYCLES, RAM_SEQ_MAX_ACCESS);
  end

  ram_seq_state_t             r_state;
  ram_seq_src_t               r_src;
  logic                       r_we;
  logic [RAM_SEQ_CNT_W-1:0]   r_cnt;

  logic                       w_gnt_valid;
  logic                       w_gnt_src_raw;
  ram_seq_src_t               w_gnt_src;
  logic                       w_advance;

  assign w_advance = (r_state == IDLE) && w_gnt_valid;
  assign w_gnt_src = ram_seq_src_t'(w_gnt_src_raw);

  ram_seq_arb u_arb (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_fetch_req     (fetch_req),
    .i_data_req      (data_req),
    .i_advance       (w_advance),
    .o_grant_valid_c (w_gnt_valid),
    .o_grant_src_c   (w_gnt_src_raw)
  );

  // Sequencer FSM; every output is set from the state being entered so all are flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_src     <= SRC_FETCH;
      r_we      <= 1'b0;
      r_cnt     <= '0;
      fetch_ack <= 1'b0;
      data_ack  <= 1'b0;
      ip_w      <= 1'b0;
      m_w       <= 1'b0;
      ram_r     <= 1'b0;
      ram_w     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      fetch_ack <= 1'b0;
      data_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_state <= SETUP;
            r_src   <= w_gnt_src;
            r_we    <= (w_gnt_src == SRC_DATA) && data_we;
            ip_w    <= (w_gnt_src == SRC_FETCH);
            m_w     <= (w_gnt_src == SRC_DATA);
            busy    <= 1'b1;
          end
        end
        SETUP: begin
          r_state <= ACCESS;
          r_cnt   <= LP_CNT_INIT;
          ram_r   <= ~r_we;
          ram_w   <= r_we;
          if (LP_CNT_INIT == '0) begin
            fetch_ack <= (r_src == SRC_FETCH);
            data_ack  <= (r_src == SRC_DATA);
          end
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            r_state <= HOLD;
            ram_r   <= 1'b0;
            ram_w   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - RAM_SEQ_CNT_W'(1);
            if (r_cnt == RAM_SEQ_CNT_W'(1)) begin
              fetch_ack <= (r_src == SRC_FETCH);
              data_ack  <= (r_src == SRC_DATA);
            end
          end
        end
        HOLD: begin
          r_state <= IDLE;
          ip_w    <= 1'b0;
          m_w     <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
